// File: rtl/mpu6050_sample_sequencer.sv
// ---------------------------------------------------------------------------
// mpu6050_sample_sequencer
//
// Purpose:
//   Periodically reads the six MPU6050 accelerometer output registers through
//   a byte-oriented I2C wrapper. It assembles big-endian X/Y/Z samples and
//   publishes them together with a one-cycle sample_valid strobe. After reset
//   it first issues a single power/reset write transaction (selector 4'b0010).
//
// Parameters:
//   SAMPLE_PERIOD  - clock cycles between sample frame starts
//   TIMEOUT_CYCLES - longest wait for one byte transaction before aborting
//
// Ports:
//   clk_50            in   system clock (50 MHz)
//   rst_n             in   asynchronous active-low reset
//   run               in   level, enables periodic sampling
//   byte_done         in   one-cycle strobe from wrapper, data valid this cycle
//   data[7:0]         in   byte returned by the wrapper
//   en                out  transaction request to the wrapper
//   register_selector out  transaction code to the wrapper
//   ax/ay/az[15:0]    out  signed accelerometer samples
//   sample_valid      out  one-cycle strobe, ax/ay/az updated together
//   err               out  one-cycle strobe on transaction timeout
//   busy              out  high whenever the sequencer is not idle
//   mag[17:0]         out  |ax|+|ay|+|az|
//
// Build option:
//   SEQ_MAG_EN - when defined, builds the registered magnitude output;
//                otherwise mag is tied to zero.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module mpu6050_sample_sequencer #(
    parameter int SAMPLE_PERIOD  = 1000000,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic               clk_50,
    input  logic               rst_n,
    input  logic               run,
    input  logic               byte_done,
    input  logic [7:0]         data,
    output logic               en,
    output logic [3:0]         register_selector,
    output logic signed [15:0] ax,
    output logic signed [15:0] ay,
    output logic signed [15:0] az,
    output logic               sample_valid,
    output logic               err,
    output logic               busy,
    output logic [17:0]        mag
);

    localparam int PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_STORE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    logic [2:0]         state_q, state_d;
    logic               init_q, init_d;       // current transaction is the power/reset write
    logic [2:0]         idx_q, idx_d;
    logic [PER_W-1:0]   per_cnt_q, per_cnt_d;
    logic               pending_q, pending_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [5:0][7:0]    bytes_q, bytes_d;
    logic signed [15:0] ax_q, ax_d, ay_q, ay_d, az_q, az_d;
    logic               busy_q, busy_d;
    logic               per_wrap;
    logic               load_sample;

    assign per_wrap    = (per_cnt_q == PER_W'(SAMPLE_PERIOD - 1));
    assign load_sample = (state_q == S_STORE) && !init_q && (idx_q == 3'd5);

    always_comb begin
        state_d   = state_q;
        init_d    = init_q;
        idx_d     = idx_q;
        tmo_cnt_d = tmo_cnt_q;
        pending_d = pending_q;
        bytes_d   = bytes_q;
        ax_d      = ax_q;
        ay_d      = ay_q;
        az_d      = az_q;
        per_cnt_d = per_wrap ? '0 : per_cnt_q + PER_W'(1);

        case (state_q)
            S_INIT: begin
                init_d  = 1'b1;
                idx_d   = 3'd0;
                state_d = S_ISSUE;
            end
            S_IDLE: begin
                if (pending_q) begin
                    pending_d = 1'b0;
                    idx_d     = 3'd0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // A completing byte wins over a timeout landing on the same cycle.
                if (byte_done) begin
                    if (!init_q) begin
                        bytes_d[idx_q] = data;
                    end
                    state_d = S_STORE;
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_ERR;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            S_STORE: begin
                if (init_q) begin
                    init_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (idx_q < 3'd5) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_ISSUE;
                end else begin
                    ax_d    = {bytes_q[0], bytes_q[1]};
                    ay_d    = {bytes_q[2], bytes_q[3]};
                    az_d    = {bytes_q[4], bytes_q[5]};
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                // Partial frame is dropped; published samples stay as they were.
                init_d  = 1'b0;
                idx_d   = 3'd0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Only one frame can be queued; further wraps while busy are lost.
        if (per_wrap && run) begin
            pending_d = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_INIT;
            init_q    <= 1'b0;
            idx_q     <= 3'd0;
            per_cnt_q <= '0;
            pending_q <= 1'b0;
            tmo_cnt_q <= '0;
            bytes_q   <= '0;
            ax_q      <= '0;
            ay_q      <= '0;
            az_q      <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            init_q    <= init_d;
            idx_q     <= idx_d;
            per_cnt_q <= per_cnt_d;
            pending_q <= pending_d;
            tmo_cnt_q <= tmo_cnt_d;
            bytes_q   <= bytes_d;
            ax_q      <= ax_d;
            ay_q      <= ay_d;
            az_q      <= az_d;
            busy_q    <= busy_d;
        end
    end

    assign en                = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign register_selector = !en    ? 4'd0 :
                               init_q ? 4'b0010 : (4'd3 + {1'b0, idx_q});
    assign sample_valid      = (state_q == S_DONE);
    assign err               = (state_q == S_ERR);
    assign busy              = busy_q;
    assign ax                = ax_q;
    assign ay                = ay_q;
    assign az                = az_q;

`ifdef SEQ_MAG_EN
    logic [17:0] mag_q, mag_d;

    // Widened to 17 bits so that |-32768| = 32768 is representable.
    function automatic logic [16:0] abs16(input logic signed [15:0] v);
        logic signed [16:0] w;
        w = v;
        return v[15] ? $unsigned(-w) : $unsigned(w);
    endfunction

    always_comb begin
        mag_d = mag_q;
        if (load_sample) begin
            mag_d = 18'(abs16({bytes_q[0], bytes_q[1]}))
                  + 18'(abs16({bytes_q[2], bytes_q[3]}))
                  + 18'(abs16({bytes_q[4], bytes_q[5]}));
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            mag_q <= '0;
        end else begin
            mag_q <= mag_d;
        end
    end

    assign mag = mag_q;
`else
    assign mag = '0;
`endif

endmodule

// File: tb/tb_mpu6050_sample_sequencer.sv
`timescale 1ns/1ps

module tb_mpu6050_sample_sequencer;

    localparam int SP = 20;
    localparam int TO = 100;

    logic               clk_50 = 1'b0;
    logic               rst_n = 1'b0;
    logic               run = 1'b0;
    logic               byte_done = 1'b0;
    logic [7:0]         data = 8'h00;
    logic               en;
    logic [3:0]         register_selector;
    logic signed [15:0] ax, ay, az;
    logic               sample_valid;
    logic               err;
    logic               busy;
    logic [17:0]        mag;

    int checks = 0;
    int failures = 0;
    int sv_count = 0;

    // Last published sample according to the transaction-level model.
    logic [15:0] m_ax = 16'h0, m_ay = 16'h0, m_az = 16'h0;

    mpu6050_sample_sequencer #(.SAMPLE_PERIOD(SP), .TIMEOUT_CYCLES(TO)) dut (
        .clk_50(clk_50), .rst_n(rst_n), .run(run), .byte_done(byte_done), .data(data),
        .en(en), .register_selector(register_selector), .ax(ax), .ay(ay), .az(az),
        .sample_valid(sample_valid), .err(err), .busy(busy), .mag(mag)
    );

    always #10 clk_50 = ~clk_50;

    always @(posedge clk_50) begin
        if (sample_valid === 1'b1) sv_count <= sv_count + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int absi(input logic [15:0] v);
        int s;
        s = int'($signed(v));
        return (s < 0) ? -s : s;
    endfunction

    // Acts as the I2C wrapper for one transaction.
    task automatic serve_byte(input logic [3:0] sel, input logic [7:0] d, input int dly);
        int n;
        bit stable;
        n = 0;
        while (en !== 1'b1 && n < 200) begin @(negedge clk_50); n++; end
        check("req_en", en, 1);
        check("req_sel", register_selector, sel);
        stable = 1'b1;
        repeat (dly) begin
            @(negedge clk_50);
            if (en !== 1'b1 || register_selector !== sel) stable = 1'b0;
        end
        check("req_hold", stable, 1);
        byte_done = 1'b1;
        data = d;
        @(negedge clk_50);
        byte_done = 1'b0;
        data = 8'($urandom);
        check("en_drop", en, 0);
    endtask

    task automatic serve_frame(input logic [5:0][7:0] b, input int dly, input bit b2b, input bit drop_run);
        int n, d, c0;
        logic [15:0] eax, eay, eaz;
        logic [17:0] emag;
        c0 = sv_count;
        for (int i = 0; i < 6; i++) begin
            d = (dly > 0) ? dly : int'($urandom_range(40, 1));
            serve_byte(4'd3 + 4'(i), b[i], d);
            if (drop_run && i == 0) run = 1'b0;
        end
        eax = {b[0], b[1]};
        eay = {b[2], b[3]};
        eaz = {b[4], b[5]};
`ifdef SEQ_MAG_EN
        emag = 18'(absi(eax) + absi(eay) + absi(eaz));
`else
        emag = 18'd0;
`endif
        n = 0;
        while (sample_valid !== 1'b1 && n < 5) begin @(negedge clk_50); n++; end
        check("sv_seen", sample_valid, 1);
        check("ax", $unsigned(ax), eax);
        check("ay", $unsigned(ay), eay);
        check("az", $unsigned(az), eaz);
        check("mag", mag, emag);
        m_ax = eax; m_ay = eay; m_az = eaz;
        @(negedge clk_50);
        check("sv_single", sample_valid, 0);
        check("sv_count", sv_count - c0, 1);
        if (b2b) begin
            @(negedge clk_50);
            check("b2b_start", en, 1);
        end
    endtask

    task automatic random_bytes(output logic [5:0][7:0] b);
        for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
    endtask

    // With run low, at most one already-pending frame may still run, then silence.
    task automatic drain();
        int n;
        bit quiet;
        logic [5:0][7:0] b;
        run = 1'b0;
        n = 0;
        while (en !== 1'b1 && n < 5) begin @(negedge clk_50); n++; end
        if (en === 1'b1) begin
            random_bytes(b);
            serve_frame(b, 5, 1'b0, 1'b0);
        end
        quiet = 1'b1;
        repeat (3 * SP) begin
            @(negedge clk_50);
            if (en !== 1'b0 || sample_valid !== 1'b0) quiet = 1'b0;
        end
        check("drain_quiet", quiet, 1);
    endtask

    initial begin
        logic [5:0][7:0] fb;
        bit quiet;
        int n, c, svc;

        // Reset state
        repeat (3) @(negedge clk_50);
        check("rst_ctrl", {en, register_selector, sample_valid, err, busy}, 0);
        check("rst_data", {ax, ay, az}, 0);
        check("rst_mag", mag, 0);

        // Power/reset write after release, answered after 50 cycles
        rst_n = 1'b1;
        serve_byte(4'b0010, 8'h5A, 50);
        @(negedge clk_50);
        check("init_idle_busy", busy, 0);
        check("init_idle_en", en, 0);

        // Spurious byte_done while idle
        byte_done = 1'b1;
        data = 8'hAA;
        @(negedge clk_50);
        byte_done = 1'b0;
        quiet = 1'b1;
        repeat (5) begin
            if (busy !== 1'b0 || en !== 1'b0 || sample_valid !== 1'b0) quiet = 1'b0;
            @(negedge clk_50);
        end
        check("spurious_idle", quiet, 1);

        // Directed frame, then overrun frames back-to-back (10-cycle bytes, period 20)
        run = 1'b1;
        fb[0] = 8'h12; fb[1] = 8'h34; fb[2] = 8'hFF;
        fb[3] = 8'hFE; fb[4] = 8'h80; fb[5] = 8'h00;
        serve_frame(fb, 10, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            random_bytes(fb);
            serve_frame(fb, 10, 1'b1, 1'b0);
        end

        // Random data with random byte latencies
        for (int k = 0; k < 3; k++) begin
            random_bytes(fb);
            serve_frame(fb, 0, 1'b0, 1'b0);
        end

        // run dropped mid-frame: frame completes, no new frames afterwards
        random_bytes(fb);
        serve_frame(fb, 0, 1'b0, 1'b1);
        drain();

        // Timeout on byte 3
        run = 1'b1;
        serve_byte(4'd3, 8'($urandom), 4);
        run = 1'b0;
        serve_byte(4'd4, 8'($urandom), 4);
        serve_byte(4'd5, 8'($urandom), 4);
        n = 0;
        while (en !== 1'b1 && n < 200) begin @(negedge clk_50); n++; end
        check("tmo_req_sel", register_selector, 4'd6);
        svc = sv_count;
        c = 0;
        while (err !== 1'b1 && c < 300) begin @(negedge clk_50); c++; end
        check("err_seen", err, 1);
        check("err_latency", c, TO + 1);
        check("err_en", en, 0);
        check("err_keep_data", {ax, ay, az}, {m_ax, m_ay, m_az});
        check("err_no_sv", sv_count - svc, 0);
        @(negedge clk_50);
        check("err_single", err, 0);
        drain();

        // Asynchronous reset during byte 2
        run = 1'b1;
        serve_byte(4'd3, 8'($urandom), 5);
        serve_byte(4'd4, 8'($urandom), 5);
        n = 0;
        while (en !== 1'b1 && n < 200) begin @(negedge clk_50); n++; end
        check("arst_byte2_sel", register_selector, 4'd5);
        repeat (3) @(negedge clk_50);
        svc = sv_count;
        #3 rst_n = 1'b0;
        #1;
        check("arst_ctrl", {en, register_selector, sample_valid, err, busy}, 0);
        check("arst_data", {ax, ay, az}, 0);
        check("arst_mag", mag, 0);
        @(negedge clk_50);
        run = 1'b0;
        rst_n = 1'b1;
        serve_byte(4'b0010, 8'h00, 5);
        @(negedge clk_50);
        check("arst_idle_busy", busy, 0);
        check("arst_no_sv", sv_count - svc, 0);
        check("arst_data_after", {ax, ay, az}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
